// File: rtl/mem_dma_engine.sv
// Byte-wide RAM initiator: copies LEN bytes from SRC to DST, or fills LEN bytes at DST with a constant.
// Owns the RAM port while o_busy is high; the address and write strobe are decoded from the current state.
module mem_dma_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_mode,
  input  logic [AW-1:0] i_src,
  input  logic [AW-1:0] i_dst,
  input  logic [AW:0]   i_len,
  input  logic [DW-1:0] i_fill_val,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_mem_A,
  output logic [DW-1:0] o_mem_WD,
  output logic          o_mem_WE,
  input  logic [DW-1:0] i_mem_RD
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_src_ptr;
  logic [AW-1:0] r_dst_ptr;
  logic [AW:0]   r_cnt;
  logic          r_mode;
  logic [DW-1:0] r_fill;
  logic [DW-1:0] r_data;
  logic [AW:0]   w_len_clamped;

  assign w_len_clamped = (i_len > LEN_MAX) ? LEN_MAX : i_len;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_src_ptr <= '0;
      r_dst_ptr <= '0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_fill    <= '0;
      r_data    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_src_ptr <= i_src;
            r_dst_ptr <= i_dst;
            r_mode    <= i_mode;
            r_fill    <= i_fill_val;
            r_cnt     <= w_len_clamped;
          end
        end
        S_READ: begin
          r_data    <= i_mem_RD;
          r_src_ptr <= r_src_ptr + AW'(1);
        end
        S_WRITE: begin
          r_dst_ptr <= r_dst_ptr + AW'(1);
          r_cnt     <= r_cnt - (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are pure state decodes so an async reset silences the RAM port immediately.
  always_comb begin
    w_next   = r_state;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    o_mem_A  = '0;
    o_mem_WD = '0;
    o_mem_WE = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_len_clamped == '0) w_next = S_DONE;
          else if (i_mode)         w_next = S_WRITE;
          else                     w_next = S_READ;
        end
      end
      S_READ: begin
        o_busy  = 1'b1;
        o_mem_A = r_src_ptr;
        w_next  = S_WRITE;
      end
      S_WRITE: begin
        o_busy   = 1'b1;
        o_mem_A  = r_dst_ptr;
        o_mem_WD = r_mode ? r_fill : r_data;
        o_mem_WE = 1'b1;
        if (r_cnt == (AW+1)'(1)) w_next = S_DONE;
        else if (r_mode)         w_next = S_WRITE;
        else                     w_next = S_READ;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed bench for mem_dma_engine: a table of transfers checked against cycle counts and a RAM model,
// plus hand-written sequences for start-while-busy and reset mid-transfer.
module tb_mem_dma_engine;

  logic       clk;
  logic       rstN;
  logic       start;
  logic       mode;
  logic [7:0] src;
  logic [7:0] dst;
  logic [8:0] len;
  logic [7:0] fillVal;
  logic       busy;
  logic       done;
  logic [7:0] memA;
  logic [7:0] memWD;
  logic       memWE;
  logic [7:0] memRD;

  logic [7:0] ram[256];
  logic [7:0] expRam[256];

  int checks = 0;
  int errors = 0;

  mem_dma_engine #(.AW(8), .DW(8)) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_start(start),
    .i_mode(mode),
    .i_src(src),
    .i_dst(dst),
    .i_len(len),
    .i_fill_val(fillVal),
    .o_busy(busy),
    .o_done(done),
    .o_mem_A(memA),
    .o_mem_WD(memWD),
    .o_mem_WE(memWE),
    .i_mem_RD(memRD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign memRD = ram[memA];
  always @(posedge clk) if (memWE) ram[memA] <= memWD;

  typedef struct {
    string      name;
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [8:0] len;
    logic [7:0] fill;
    int         expDone;
    int         expBusy;
    int         expWe;
    logic [7:0] chkAddr1;
    logic [7:0] chkVal1;
    logic [7:0] chkAddr2;
    logic [7:0] chkVal2;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference copy/fill in ascending byte order, applied to a snapshot of the RAM.
  task automatic modelTransfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                               input logic [8:0] l, input logic [7:0] f);
    int n;
    logic [7:0] sa;
    logic [7:0] da;
    n = (l > 9'd256) ? 256 : int'(l);
    sa = s;
    da = d;
    for (int i = 0; i < 256; i++) expRam[i] = ram[i];
    for (int i = 0; i < n; i++) begin
      expRam[da] = m ? f : expRam[sa];
      sa = sa + 8'd1;
      da = da + 8'd1;
    end
  endtask

  task automatic compareRam(input string name);
    int bad;
    int firstAddr;
    bad = 0;
    firstAddr = 0;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== expRam[i]) begin
        if (bad == 0) firstAddr = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL %s: %0d bytes differ, first at 0x%0h got 0x%0h expected 0x%0h",
               name, bad, firstAddr, ram[firstAddr], expRam[firstAddr]);
    end
  endtask

  // Issues one command and observes every cycle until done, plus a short tail to catch extra pulses.
  task automatic applyStimulus(input logic m, input logic [7:0] s, input logic [7:0] d,
                               input logic [8:0] l, input logic [7:0] f,
                               input int injectCycle, input logic [7:0] altDst,
                               output int doneCycle, output int busyCycles, output int weCycles,
                               output int doneCount, output int doneA, output int doneWe);
    int tail;
    doneCycle = -1;
    busyCycles = 0;
    weCycles = 0;
    doneCount = 0;
    doneA = -1;
    doneWe = -1;
    tail = -1;
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; fillVal = f; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      if (busy) busyCycles++;
      if (memWE) weCycles++;
      if (done) begin
        doneCount++;
        if (doneCycle < 0) begin
          doneCycle = k;
          doneA = int'(memA);
          doneWe = int'(memWE);
          tail = 4;
        end
      end
      if (k == injectCycle) begin
        start = 1'b1;
        dst = altDst;
      end else begin
        start = 1'b0;
      end
      if (tail == 0) break;
      if (tail > 0) tail--;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int dc, bc, wc, dn, da, dw;

    vecs[0] = '{"copy4",     1'b0, 8'h10, 8'h40, 9'd4,     8'h00,   9,   8,   4, 8'h40, 8'hAA, 8'h43, 8'hDD};
    vecs[1] = '{"fillWrap",  1'b1, 8'h00, 8'hFE, 9'd4,     8'h5A,   5,   4,   4, 8'hFF, 8'h5A, 8'h02, 8'hFD};
    vecs[2] = '{"lenZero",   1'b0, 8'h10, 8'h60, 9'd0,     8'h00,   1,   0,   0, 8'h60, 8'h9F, 8'h40, 8'hAA};
    vecs[3] = '{"copyWrap",  1'b0, 8'hFE, 8'h50, 9'd3,     8'h00,   7,   6,   3, 8'h50, 8'h5A, 8'h52, 8'h5A};
    vecs[4] = '{"overlap",   1'b0, 8'h20, 8'h21, 9'd2,     8'h00,   5,   4,   2, 8'h21, 8'h11, 8'h22, 8'h11};
    vecs[5] = '{"fillClamp", 1'b1, 8'h00, 8'h00, 9'h1FF,   8'h3C, 257, 256, 256, 8'h00, 8'h3C, 8'hFF, 8'h3C};

    for (int i = 0; i < 256; i++) ram[i] = 8'hFF - 8'(i);
    ram[8'h10] = 8'hAA; ram[8'h11] = 8'hBB; ram[8'h12] = 8'hCC; ram[8'h13] = 8'hDD;
    ram[8'h20] = 8'h11; ram[8'h21] = 8'h22;

    rstN = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fillVal = '0;
    #12;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset memWE", int'(memWE), 0);
    checkOutput("reset memA", int'(memA), 0);
    checkOutput("reset memWD", int'(memWD), 0);
    @(negedge clk);
    rstN = 1'b1;

    for (int v = 0; v < 6; v++) begin
      modelTransfer(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill);
      applyStimulus(vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill, 0, 8'h00,
                    dc, bc, wc, dn, da, dw);
      checkOutput({vecs[v].name, " doneCycle"}, dc, vecs[v].expDone);
      checkOutput({vecs[v].name, " busyCycles"}, bc, vecs[v].expBusy);
      checkOutput({vecs[v].name, " weCycles"}, wc, vecs[v].expWe);
      checkOutput({vecs[v].name, " donePulses"}, dn, 1);
      checkOutput({vecs[v].name, " memA in DONE"}, da, 0);
      checkOutput({vecs[v].name, " memWE in DONE"}, dw, 0);
      checkOutput({vecs[v].name, " byte1"}, int'(ram[vecs[v].chkAddr1]), int'(vecs[v].chkVal1));
      checkOutput({vecs[v].name, " byte2"}, int'(ram[vecs[v].chkAddr2]), int'(vecs[v].chkVal2));
      compareRam({vecs[v].name, " ram"});
    end

    // A second start mid-copy with another destination must be dropped entirely.
    ram[8'h30] = 8'h01; ram[8'h31] = 8'h02; ram[8'h32] = 8'h03;
    modelTransfer(1'b0, 8'h30, 8'h70, 9'd3, 8'h00);
    applyStimulus(1'b0, 8'h30, 8'h70, 9'd3, 8'h00, 2, 8'h90, dc, bc, wc, dn, da, dw);
    checkOutput("startBusy doneCycle", dc, 7);
    checkOutput("startBusy donePulses", dn, 1);
    checkOutput("startBusy byte 0x72", int'(ram[8'h72]), 8'h03);
    checkOutput("startBusy byte 0x90", int'(ram[8'h90]), 8'h3C);
    compareRam("startBusy ram");

    // Reset asserted during the third WRITE of an 8-byte fill.
    @(negedge clk);
    mode = 1'b1; dst = 8'h80; len = 9'd8; fillVal = 8'h77; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midReset WE before", int'(memWE), 1);
    rstN = 1'b0;
    #1;
    checkOutput("midReset memWE", int'(memWE), 0);
    checkOutput("midReset busy", int'(busy), 0);
    checkOutput("midReset done", int'(done), 0);
    checkOutput("midReset memA", int'(memA), 0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("midReset byte 0x80", int'(ram[8'h80]), 8'h77);
    checkOutput("midReset byte 0x81", int'(ram[8'h81]), 8'h77);
    checkOutput("midReset byte 0x82", int'(ram[8'h82]), 8'h3C);

    modelTransfer(1'b1, 8'h00, 8'h82, 9'd1, 8'h99);
    applyStimulus(1'b1, 8'h00, 8'h82, 9'd1, 8'h99, 0, 8'h00, dc, bc, wc, dn, da, dw);
    checkOutput("afterReset doneCycle", dc, 2);
    checkOutput("afterReset byte 0x82", int'(ram[8'h82]), 8'h99);
    compareRam("afterReset ram");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
